// File: rtl/core_dmem_arbiter_if.sv
// core_dmem_arbiter_if -- one data-memory request/response channel.
//
// Carries a request (req/gnt plus wen, strb, addr, wdata) and a response
// (recv/ack plus error, rdata).
//   master : requester side; drives the request and ack, receives gnt and
//            the response.
//   slave  : responder side; receives the request and ack, drives gnt and
//            the response.
interface core_dmem_arbiter_if #(
  parameter int XLEN = 64
);
  logic            req;
  logic            gnt;
  logic            wen;
  logic [7:0]      strb;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            recv;
  logic            ack;
  logic            error;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, wen, strb, addr, wdata, ack,
    input  gnt, recv, error, rdata
  );

  modport slave (
    input  req, wen, strb, addr, wdata, ack,
    output gnt, recv, error, rdata
  );
endinterface

// File: rtl/core_dmem_arbiter.sv
// core_dmem_arbiter -- two-requester data-memory arbiter.
//
// Requester 0 (LSU) and requester 1 (secondary port) share one memory bus.
// Accepted requests record their requester ID in an owner FIFO of depth
// OUTSTANDING so that in-order responses return to the right requester.
// A request left waiting on the bus holds the arbitration lock until the
// memory grants it.
//
// Ports:
//   g_clk      clock, rising edge
//   g_reset    asynchronous, active-high reset
//   r0, r1     requester channels (slave modport)
//   m          memory bus channel (master modport)
//   stray_rsp  pulses when a response arrives with nothing outstanding
//
// Build option: define CORE_DMEM_ARB_RR_EN for round-robin arbitration
// between simultaneous requests; otherwise requester 0 has fixed priority.
module core_dmem_arbiter #(
  parameter int XLEN        = 64,
  parameter int OUTSTANDING = 2
) (
  input  logic                g_clk,
  input  logic                g_reset,
  core_dmem_arbiter_if.slave  r0,
  core_dmem_arbiter_if.slave  r1,
  core_dmem_arbiter_if.master m,
  output logic                stray_rsp
);

  localparam int              PW       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [2:0]      CNT_MAX  = 3'(OUTSTANDING);
  localparam logic [PW-1:0]   PTR_LAST = PW'(OUTSTANDING - 1);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic [2:0]             count_q, count_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [OUTSTANDING-1:0] fifo_q, fifo_d;
`ifdef CORE_DMEM_ARB_RR_EN
  logic                   last_gnt_q, last_gnt_d;
`endif

  logic run;
  logic sel;
  logic rsel_req;
  logic req;
  logic push;
  logic pop;
  logic has_out;
  logic owner;
  logic ack;

  // Outputs are masked while reset is high; only the stray-response ack
  // path stays live so the bus is never left hanging.
  assign run     = ~g_reset;
  assign has_out = (count_q != 3'd0);
  assign owner   = fifo_q[rptr_q];

  always_comb begin
    sel = 1'b0;
    if (state_q == ST_HOLD) begin
      sel = sel_q;
    end else if (r0.req && r1.req) begin
`ifdef CORE_DMEM_ARB_RR_EN
      sel = ~last_gnt_q;
`else
      sel = 1'b0;
`endif
    end else begin
      sel = r1.req;
    end
  end

  // Full FIFO blocks the request even if a response pops in the same cycle.
  assign rsel_req = sel ? r1.req : r0.req;
  assign req      = run && rsel_req && (count_q < CNT_MAX);
  assign push     = req && m.gnt;
  // With nothing outstanding the response is stray and is always accepted.
  assign ack      = has_out ? (owner ? r1.ack : r0.ack) : m.recv;
  assign pop      = m.recv && ack && has_out;

  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fifo_d  = fifo_q;
`ifdef CORE_DMEM_ARB_RR_EN
    last_gnt_d = last_gnt_q;
`endif

    unique case (state_q)
      ST_IDLE: if (req && !m.gnt) state_d = ST_HOLD;
      ST_HOLD: if (m.gnt)         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      fifo_d[wptr_q] = sel;
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
`ifdef CORE_DMEM_ARB_RR_EN
      last_gnt_d = sel;
`endif
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_q     <= '0;
`ifdef CORE_DMEM_ARB_RR_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_q     <= fifo_d;
`ifdef CORE_DMEM_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  assign m.req   = req;
  assign m.wen   = run && (sel ? r1.wen : r0.wen);
  assign m.strb  = run ? (sel ? r1.strb  : r0.strb)  : '0;
  assign m.addr  = run ? (sel ? r1.addr  : r0.addr)  : '0;
  assign m.wdata = run ? (sel ? r1.wdata : r0.wdata) : '0;
  assign m.ack   = ack;

  assign r0.gnt   = push && !sel;
  assign r1.gnt   = push && sel;
  assign r0.recv  = run && m.recv && has_out && !owner;
  assign r1.recv  = run && m.recv && has_out && owner;
  assign r0.error = run && m.error;
  assign r1.error = run && m.error;
  assign r0.rdata = run ? m.rdata : '0;
  assign r1.rdata = run ? m.rdata : '0;

  assign stray_rsp = run && m.recv && !has_out;

endmodule
